// File: rtl/instruction_decoder_if.sv
// Decode-stage bus: fetched instruction word in, decoded fields and class flags out.
// Optional `illegal` output is present when ID_ILLEGAL_FLAG_EN is defined.
interface instruction_decoder_if;
    logic [0:31] instruction;
    logic [0:4]  rA_address;
    logic [0:4]  rB_address;
    logic [0:4]  rD_address;
    logic [0:5]  alu_operation;
    logic [0:15] immediate_address;
    logic [0:2]  ppp;
    logic [0:1]  ww;
    logic        alu;
    logic        sfu;
    logic        ld;
    logic        sd;
    logic        bez;
    logic        bnez;
    logic        nop;
`ifdef ID_ILLEGAL_FLAG_EN
    logic        illegal;

    modport master (
        output instruction,
        input  rA_address, rB_address, rD_address, alu_operation,
        input  immediate_address, ppp, ww,
        input  alu, sfu, ld, sd, bez, bnez, nop, illegal
    );

    modport slave (
        input  instruction,
        output rA_address, rB_address, rD_address, alu_operation,
        output immediate_address, ppp, ww,
        output alu, sfu, ld, sd, bez, bnez, nop, illegal
    );
`else
    modport master (
        output instruction,
        input  rA_address, rB_address, rD_address, alu_operation,
        input  immediate_address, ppp, ww,
        input  alu, sfu, ld, sd, bez, bnez, nop
    );

    modport slave (
        input  instruction,
        output rA_address, rB_address, rD_address, alu_operation,
        output immediate_address, ppp, ww,
        output alu, sfu, ld, sd, bez, bnez, nop
    );
`endif
endinterface

// File: rtl/instruction_decoder.sv
// Vector CPU decode stage: one-cycle registered decode of the 32-bit instruction word.
// Define ID_ILLEGAL_FLAG_EN to add the registered `illegal` output.
module instruction_decoder (
    input  logic                clk,
    input  logic                reset,
    instruction_decoder_if.slave dec
);

    localparam logic [0:5] OP_RTYPE = 6'b101010;
    localparam logic [0:5] OP_VLD   = 6'b100000;
    localparam logic [0:5] OP_VSD   = 6'b100001;
    localparam logic [0:5] OP_VBEZ  = 6'b100010;
    localparam logic [0:5] OP_VBNEZ = 6'b100011;
    localparam logic [0:5] OP_VNOP  = 6'b111100;

    logic [0:5]  opcode;
    logic [0:5]  func;
    logic [0:4]  rd_n;
    logic [0:4]  ra_n;
    logic [0:4]  rb_n;
    logic [0:5]  op_n;
    logic [0:15] imm_n;
    logic [0:2]  ppp_n;
    logic [0:1]  ww_n;
    logic        alu_n;
    logic        sfu_n;
    logic        ld_n;
    logic        sd_n;
    logic        bez_n;
    logic        bnez_n;
    logic        nop_n;

    assign opcode = dec.instruction[0:5];
    assign func   = dec.instruction[26:31];

    // Classify opcode/function and select only the fields the format uses
    always_comb begin
        rd_n   = '0;
        ra_n   = '0;
        rb_n   = '0;
        op_n   = '0;
        imm_n  = '0;
        ppp_n  = '0;
        ww_n   = '0;
        alu_n  = 1'b0;
        sfu_n  = 1'b0;
        ld_n   = 1'b0;
        sd_n   = 1'b0;
        bez_n  = 1'b0;
        bnez_n = 1'b0;
        nop_n  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                    6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14:
                        alu_n = 1'b1;
                    6'd15, 6'd16, 6'd17, 6'd18, 6'd19:
                        sfu_n = 1'b1;
                    default:
                        nop_n = 1'b1;
                endcase
                if (!nop_n) begin
                    rd_n  = dec.instruction[6:10];
                    ra_n  = dec.instruction[11:15];
                    rb_n  = dec.instruction[16:20];
                    ppp_n = dec.instruction[21:23];
                    ww_n  = dec.instruction[24:25];
                    op_n  = func;
                end
            end
            OP_VLD, OP_VSD, OP_VBEZ, OP_VBNEZ: begin
                rd_n   = dec.instruction[6:10];
                imm_n  = dec.instruction[16:31];
                ld_n   = (opcode == OP_VLD);
                sd_n   = (opcode == OP_VSD);
                bez_n  = (opcode == OP_VBEZ);
                bnez_n = (opcode == OP_VBNEZ);
            end
            default:
                nop_n = 1'b1;
        endcase
    end

    // Register all decode outputs; reset clears them immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec.rD_address        <= '0;
            dec.rA_address        <= '0;
            dec.rB_address        <= '0;
            dec.alu_operation     <= '0;
            dec.immediate_address <= '0;
            dec.ppp               <= '0;
            dec.ww                <= '0;
            dec.alu               <= 1'b0;
            dec.sfu               <= 1'b0;
            dec.ld                <= 1'b0;
            dec.sd                <= 1'b0;
            dec.bez               <= 1'b0;
            dec.bnez              <= 1'b0;
            dec.nop               <= 1'b0;
        end else begin
            dec.rD_address        <= rd_n;
            dec.rA_address        <= ra_n;
            dec.rB_address        <= rb_n;
            dec.alu_operation     <= op_n;
            dec.immediate_address <= imm_n;
            dec.ppp               <= ppp_n;
            dec.ww                <= ww_n;
            dec.alu               <= alu_n;
            dec.sfu               <= sfu_n;
            dec.ld                <= ld_n;
            dec.sd                <= sd_n;
            dec.bez               <= bez_n;
            dec.bnez              <= bnez_n;
            dec.nop               <= nop_n;
        end
    end

`ifdef ID_ILLEGAL_FLAG_EN
    logic ill_n;

    // Any NOP that did not come from a genuine VNOP is an illegal encoding
    assign ill_n = nop_n && (opcode != OP_VNOP);

    // Register the illegal-encoding flag alongside the decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) dec.illegal <= 1'b0;
        else       dec.illegal <= ill_n;
    end
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Randomized self-checking bench for instruction_decoder against a field-rule model.
// Honours ID_ILLEGAL_FLAG_EN when defined at build time.
module tb_instruction_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    instruction_decoder_if bus();

    instruction_decoder dut (
        .clk   (clk),
        .reset (reset),
        .dec   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd, ra, rb, op, imm, ppp, ww;
        int alu, sfu, ld, sd, bez, bnez, nop, ill;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Reference: field extraction by shifting the MSB-first word
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int op, fn;
        e  = zero_exp();
        op = int'(w >> 26) & 63;
        fn = int'(w) & 63;
        if (op == 42 && fn >= 1 && fn <= 19 && fn != 11) begin
            e.rd  = int'(w >> 21) & 31;
            e.ra  = int'(w >> 16) & 31;
            e.rb  = int'(w >> 11) & 31;
            e.ppp = int'(w >> 8) & 7;
            e.ww  = int'(w >> 6) & 3;
            e.op  = fn;
            if (fn <= 14) e.alu = 1;
            else          e.sfu = 1;
        end else if (op >= 32 && op <= 35) begin
            e.rd   = int'(w >> 21) & 31;
            e.imm  = int'(w) & 16'hFFFF;
            e.ld   = (op == 32) ? 1 : 0;
            e.sd   = (op == 33) ? 1 : 0;
            e.bez  = (op == 34) ? 1 : 0;
            e.bnez = (op == 35) ? 1 : 0;
        end else begin
            e.nop = 1;
            e.ill = (op == 60) ? 0 : 1;
        end
        return e;
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".rD"},   32'(bus.rD_address),        e.rd);
        chk({tag, ".rA"},   32'(bus.rA_address),        e.ra);
        chk({tag, ".rB"},   32'(bus.rB_address),        e.rb);
        chk({tag, ".func"}, 32'(bus.alu_operation),     e.op);
        chk({tag, ".imm"},  32'(bus.immediate_address), e.imm);
        chk({tag, ".ppp"},  32'(bus.ppp),               e.ppp);
        chk({tag, ".ww"},   32'(bus.ww),                e.ww);
        chk({tag, ".alu"},  32'(bus.alu),               e.alu);
        chk({tag, ".sfu"},  32'(bus.sfu),               e.sfu);
        chk({tag, ".ld"},   32'(bus.ld),                e.ld);
        chk({tag, ".sd"},   32'(bus.sd),                e.sd);
        chk({tag, ".bez"},  32'(bus.bez),               e.bez);
        chk({tag, ".bnez"}, 32'(bus.bnez),              e.bnez);
        chk({tag, ".nop"},  32'(bus.nop),               e.nop);
`ifdef ID_ILLEGAL_FLAG_EN
        chk({tag, ".ill"},  32'(bus.illegal),           e.ill);
`endif
    endtask

    // Present one word, let one edge pass, compare against the model
    task automatic apply(input string tag, input logic [31:0] w);
        bus.instruction = w;
        @(posedge clk);
        #1;
        check_all(tag, model(w));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3: w[31:26] = 6'b101010;
            4: w[31:26] = 6'b100000;
            5: w[31:26] = 6'b100001;
            6: w[31:26] = 6'b100010;
            7: w[31:26] = 6'b100011;
            8: w[31:26] = 6'b111100;
            default: ;
        endcase
        if (sel <= 3) w[5:0] = 6'($urandom_range(0, 24));
        return w;
    endfunction

    initial begin
        bus.instruction = $urandom;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all("rst_hold", zero_exp());
        end
        #2 reset = 1'b0;

        apply("vadd", 32'b10101000011000010001000010000110);
        apply("vdiv", 32'b10101000011000010001000010001111);
        apply("vld",  32'b10000000101000000000000000010000);
        apply("vsd",  {6'b100001, 5'd7, 5'd0, 16'hFFFF});
        apply("vbez", {6'b100010, 5'd7, 5'd0, 16'hFFFF});
        apply("vbnz", {6'b100011, 5'd7, 5'd0, 16'hFFFF});
        apply("vnop", 32'b11110000000000000000000000000000);
        apply("op3f", {6'b111111, 26'h2AB_CDEF});
        apply("fn3f", {6'b101010, 5'd3, 5'd1, 5'd2, 3'd5, 2'd1, 6'b111111});
        apply("fn0b", {6'b101010, 5'd9, 5'd4, 5'd6, 3'd7, 2'd3, 6'd11});
        apply("vand", {6'b101010, 5'd31, 5'd30, 5'd29, 3'd7, 2'd3, 6'd1});

        #2 reset = 1'b1;
        #1 check_all("rst_async", zero_exp());
        @(posedge clk);
        #1 check_all("rst_held", zero_exp());
        #2 reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            apply("rand", rand_word());
            if (i == 150) begin
                #2 reset = 1'b1;
                #1 check_all("rst_mid", zero_exp());
                #2 reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
